// File: rtl/traffic_light_pkg.sv
// Shared definitions for the four-way intersection signal controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Lamp codes are one-hot {red, yellow, green}. The phase enum order is the
// service order. Each green phase is followed by the yellow phase of the same
// approach, and the last phase wraps back to the first.
package traffic_light_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // Bit 0 of a phase is set for yellow phases and clear for green phases.
  // Bits 2:1 give the approach index: S=0, E=1, N=2, W=3.
  typedef enum logic [2:0] {
    S_G = 3'd0,
    S_Y = 3'd1,
    E_G = 3'd2,
    E_Y = 3'd3,
    N_G = 3'd4,
    N_Y = 3'd5,
    W_G = 3'd6,
    W_Y = 3'd7
  } phase_t;

  localparam int DEF_GREEN_CYCLES  = 7;
  localparam int DEF_YELLOW_CYCLES = 2;

endpackage

// File: rtl/traffic_light_controller.sv
// Four-way round-robin signal controller (S, E, N, W), each slot green then yellow.
// Latency: lamps are a combinational Moore decode of the phase register; phases advance on dwell expiry.
// Backpressure: none, free-running timer with no inputs besides clk/rst.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      synchronous active-high reset: returns to South green, count 0
//   light_S  South lamps {red, yellow, green}
//   light_E  East lamps, same encoding
//   light_N  North lamps, same encoding
//   light_W  West lamps, same encoding
// GREEN_CYCLES and YELLOW_CYCLES are legal in the range 1..16.
module traffic_light_controller
  import traffic_light_pkg::*;
#(
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_S,
  output logic [2:0] light_E,
  output logic [2:0] light_N,
  output logic [2:0] light_W
);

  phase_t     ps;
  phase_t     ps_nxt;
  logic [3:0] count;
  logic [3:0] count_nxt;
  logic       dwell_done;

  // The dwell length can be 16, so it needs 5 bits. The count itself only
  // ever reaches dwell-1, which fits in 4 bits.
  function automatic logic [4:0] phase_dur(input phase_t p);
    if (p[0]) begin
      phase_dur = 5'(YELLOW_CYCLES);
    end else begin
      phase_dur = 5'(GREEN_CYCLES);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ps    <= S_G;
      count <= '0;
    end else begin
      ps    <= ps_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    ps_nxt     = ps;
    count_nxt  = count + 4'd1;
    dwell_done = ({1'b0, count} == (phase_dur(ps) - 5'd1));
    if (dwell_done) begin
      // The 3-bit add wraps W_Y back to S_G.
      ps_nxt    = phase_t'(ps + 3'd1);
      count_nxt = '0;
    end
  end

  always_comb begin
    light_S = RED;
    light_E = RED;
    light_N = RED;
    light_W = RED;
    case (ps)
      S_G:     light_S = GREEN;
      S_Y:     light_S = YELLOW;
      E_G:     light_E = GREEN;
      E_Y:     light_E = YELLOW;
      N_G:     light_N = GREEN;
      N_Y:     light_N = YELLOW;
      W_G:     light_W = GREEN;
      W_Y:     light_W = YELLOW;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench for traffic_light_controller.
// Two instances: default timing (7/2) and overridden timing (3/1), sharing clk and rst.
// The reference model derives the lamps from the number of cycles since the last reset.
module tb_traffic_light_controller;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  logic       clk;
  logic       rst;
  logic [2:0] s_a, e_a, n_a, w_a;
  logic [2:0] s_b, e_b, n_b, w_b;

  int checks;
  int failures;
  int ta;
  int tb;
  logic [11:0] prev_a;
  logic [11:0] prev_b;

  traffic_light_controller dut_a (
    .clk     (clk),
    .rst     (rst),
    .light_S (s_a),
    .light_E (e_a),
    .light_N (n_a),
    .light_W (w_a)
  );

  traffic_light_controller #(
    .GREEN_CYCLES  (3),
    .YELLOW_CYCLES (1)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .light_S (s_b),
    .light_E (e_b),
    .light_N (n_b),
    .light_W (w_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: t cycles after reset, position in rotation picks approach and colour.
  function automatic logic [11:0] model_lamps(input int t, input int g, input int y);
    int slot;
    int pos;
    int app;
    logic [2:0] col;
    logic [11:0] v;
    slot = g + y;
    pos  = t % (4 * slot);
    app  = pos / slot;
    col  = ((pos % slot) < g) ? L_G : L_Y;
    v    = {L_R, L_R, L_R, L_R};
    case (app)
      0: v[11:9] = col;
      1: v[8:6]  = col;
      2: v[5:3]  = col;
      default: v[2:0] = col;
    endcase
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got S/E/N/W=%03b/%03b/%03b/%03b required %03b/%03b/%03b/%03b",
               nm, got[11:9], got[8:6], got[5:3], got[2:0],
               exp[11:9], exp[8:6], exp[5:3], exp[2:0]);
    end
  endtask

  // One non-red lamp, legal codes only, and no green-to-red step outside reset.
  task automatic check_inv(input string nm, input logic [11:0] cur, input logic [11:0] prev,
                           input logic r);
    int  nonred;
    bit  legal;
    bit  g2r;
    nonred = 0;
    legal  = 1'b1;
    g2r    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] c;
      logic [2:0] p;
      c = cur[i*3 +: 3];
      p = prev[i*3 +: 3];
      if (c !== L_R && c !== L_Y && c !== L_G) legal = 1'b0;
      if (c !== L_R) nonred++;
      if (!r && p === L_G && c === L_R) g2r = 1'b1;
    end
    checks++;
    if (nonred != 1 || !legal || g2r) begin
      failures++;
      $display("FAIL %s got nonred=%0d legal=%0d green_to_red=%0d lamps=%012b required nonred=1 legal=1 green_to_red=0",
               nm, nonred, legal, g2r, cur);
    end
  endtask

  // Apply rst for one edge, advance both models, then compare everything.
  task automatic step(input logic r);
    logic [11:0] cur_a;
    logic [11:0] cur_b;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      ta = 0;
      tb = 0;
    end else begin
      ta++;
      tb++;
    end
    cur_a = {s_a, e_a, n_a, w_a};
    cur_b = {s_b, e_b, n_b, w_b};
    cmp("model_a", cur_a, model_lamps(ta, 7, 2));
    cmp("model_b", cur_b, model_lamps(tb, 3, 1));
    check_inv("inv_a", cur_a, prev_a, r);
    check_inv("inv_b", cur_b, prev_b, r);
    prev_a = cur_a;
    prev_b = cur_b;
  endtask

  typedef struct {
    logic       rst;
    int         n;
    logic [2:0] s;
    logic [2:0] e;
    logic [2:0] nl;
    logic [2:0] w;
  } vec_t;

  vec_t tbl[12];

  initial begin
    checks   = 0;
    failures = 0;
    ta       = 0;
    tb       = 0;
    prev_a   = '0;
    prev_b   = '0;
    rst      = 1'b0;

    // Reset then a long run: t=0..49 after release, default timing.
    tbl[0]  = '{1'b1, 1, L_G, L_R, L_R, L_R};
    tbl[1]  = '{1'b0, 6, L_G, L_R, L_R, L_R};
    tbl[2]  = '{1'b0, 2, L_Y, L_R, L_R, L_R};
    tbl[3]  = '{1'b0, 7, L_R, L_G, L_R, L_R};
    tbl[4]  = '{1'b0, 2, L_R, L_Y, L_R, L_R};
    tbl[5]  = '{1'b0, 7, L_R, L_R, L_G, L_R};
    tbl[6]  = '{1'b0, 2, L_R, L_R, L_Y, L_R};
    tbl[7]  = '{1'b0, 7, L_R, L_R, L_R, L_G};
    tbl[8]  = '{1'b0, 2, L_R, L_R, L_R, L_Y};
    tbl[9]  = '{1'b0, 7, L_G, L_R, L_R, L_R};
    tbl[10] = '{1'b0, 2, L_Y, L_R, L_R, L_R};
    tbl[11] = '{1'b0, 5, L_R, L_G, L_R, L_R};

    #2;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].rst);
        cmp($sformatf("tbl%0d_t%0d", i, ta), {s_a, e_a, n_a, w_a},
            {tbl[i].s, tbl[i].e, tbl[i].nl, tbl[i].w});
      end
    end

    // Mid-rotation reset while North is green.
    step(1'b1);
    for (int k = 0; k < 20; k++) step(1'b0);
    cmp("north_green_t20", {s_a, e_a, n_a, w_a}, {L_R, L_R, L_G, L_R});
    step(1'b1);
    cmp("mid_reset", {s_a, e_a, n_a, w_a}, {L_G, L_R, L_R, L_R});
    for (int k = 1; k < 7; k++) begin
      step(1'b0);
      cmp($sformatf("restart_green_%0d", k), {s_a, e_a, n_a, w_a}, {L_G, L_R, L_R, L_R});
    end
    step(1'b0);
    cmp("restart_yellow", {s_a, e_a, n_a, w_a}, {L_Y, L_R, L_R, L_R});

    // Reset held for 5 edges, no phase advance.
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      cmp($sformatf("held_reset_%0d", k), {s_a, e_a, n_a, w_a}, {L_G, L_R, L_R, L_R});
      cmp($sformatf("held_reset_b_%0d", k), {s_b, e_b, n_b, w_b}, {L_G, L_R, L_R, L_R});
    end
    for (int k = 1; k <= 16; k++) begin
      step(1'b0);
      if (k == 3) cmp("b_yellow_t3", {s_b, e_b, n_b, w_b}, {L_Y, L_R, L_R, L_R});
      if (k == 4) cmp("b_east_t4", {s_b, e_b, n_b, w_b}, {L_R, L_G, L_R, L_R});
      if (k == 7) cmp("a_yellow_t7", {s_a, e_a, n_a, w_a}, {L_Y, L_R, L_R, L_R});
      if (k == 9) cmp("a_east_t9", {s_a, e_a, n_a, w_a}, {L_R, L_G, L_R, L_R});
      if (k == 15) cmp("b_west_yellow_t15", {s_b, e_b, n_b, w_b}, {L_R, L_R, L_R, L_Y});
      if (k == 16) cmp("b_wrap_t16", {s_b, e_b, n_b, w_b}, {L_G, L_R, L_R, L_R});
    end

    // Random resets sprinkled over a long run.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
